// File: rtl/reg_serial_pkg.sv
// Shared types and constants for the register serial reader: FSM state encoding
// and the default parallel word width.
package reg_serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable parallel-in/serial-out register; shifts left (MSB out first) only
// when enabled, so a stalled consumer simply freezes the contents.
module piso_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] par_in,
   output logic             msb
);

   logic [WIDTH-1:0] data_reg;

   // Load wins over shift; the FSM never requests both in the same cycle anyway.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg <= '0;
      end else if (load) begin
         data_reg <= par_in;
      end else if (shift_en) begin
         data_reg <= {data_reg[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = data_reg[WIDTH-1];

endmodule

// File: rtl/reg_serial_reader.sv
// Captures a parallel register word on start and streams it MSB first over a
// valid/ready serial handshake, pulsing done once the final bit is accepted.
import reg_serial_pkg::*;

module reg_serial_reader #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] par_in,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             load;
   logic             fire;
   logic             msb;

   piso_shift_reg #(
      .WIDTH(WIDTH)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift_en(fire),
      .par_in  (par_in),
      .msb     (msb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= '0;
      end else if (fire) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      fire       = 1'b0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy      = 1'b1;
            ser_valid = 1'b1;
            ser_out   = msb;
            fire      = ser_ready;
            if (ser_ready && (cnt_reg == LAST_IDX)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
